mpl_wb_collector: RTL and testbench
===================================

# mpl_wb_collector

Writeback collector on the consumer side of the 2D max-pool unit in the SFU. Each pooled output word is presented with a valid strobe and a pooled-position index 0..3. The block queues these words in a small FIFO. It applies optional per-lane ReLU and writes each word to the output SRAM at `base_addr + mpl_onij`, throttled by a ready input. It pulses `done` once all four pooled positions of a tile have been written.

## Interface
Parameters:
- `psum_bw`, 16, width of one signed lane.
- `col`, 8, lanes per word.
- `depth`, 4, FIFO entries (power of two, ≥2).
- `addr_bw`, 4, SRAM address width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high. Clears all state and outputs.
- `start`  in  1  one-cycle pulse. Loads `base_addr`, clears FIFO, counters and sticky flags, enters RUN.
- `base_addr`  in  addr_bw  tile base address, sampled on `start`.
- `relu_en`  in  1  when 1, negative lanes are written as 0. Sampled on `start`.
- `mpl_valid`  in  1  pooled word valid this cycle.
- `mpl_onij`  in  2  pooled position 0..3 of the current word.
- `mpl_out`  in  psum_bw*col  pooled word. Lane i is bits [i*psum_bw +: psum_bw], signed.
- `wr_ready`  in  1  SRAM port may accept a write this cycle.
- `sram_cen`  out  1  chip enable, active-low, registered.
- `sram_wen`  out  1  write enable, active-low, registered.
- `sram_addr`  out  addr_bw  write address, registered.
- `sram_d`  out  psum_bw*col  write data, registered.
- `busy`  out  1  state is RUN or FLUSH.
- `done`  out  1  one-cycle completion pulse.
- `overflow`  out  1  sticky: a push was dropped because the FIFO was full.
- `order_err`  out  1  sticky: `mpl_onij` differed from the expected index.

## Operation
- States:
  - IDLE: `start` → RUN.
  - RUN: accepts pushes. When the 4th push is accepted (push count reaches 4) → FLUSH.
  - FLUSH: accepts no pushes. FIFO empty and write count = 4 → DONE.
  - DONE: unconditional → IDLE. `done`=1 for exactly this cycle.
- `start` in any state restarts: FIFO emptied, push/write/expected counters cleared to 0, `overflow` and `order_err` cleared, next state RUN. A write strobe already registered still completes this cycle.
- Push: in RUN with `mpl_valid`=1, the entry {mpl_onij, mpl_out} is written at the tail. This happens if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - A full FIFO with no pop drops the push, sets `overflow`, and does not increment the push count.
  - `mpl_valid` in IDLE, FLUSH or DONE is ignored and raises no flag.
- Order check: an expected-index counter starts at 0 and increments on each accepted push. If `mpl_onij` ≠ the expected index on an accepted push, `order_err` is set. The entry is still written using its own `mpl_onij`.
- Pop: FIFO non-empty and `wr_ready`=1 and state RUN or FLUSH.
  - On the pop edge: `sram_cen`=0, `sram_wen`=0, `sram_addr` = base_addr + head onij (modulo 2^addr_bw), `sram_d` = head data with ReLU applied.
  - ReLU rule: lane MSB = 1 → lane becomes 0. Otherwise the lane passes unchanged.
  - Write count increments on the pop.
- No pop on an edge: `sram_cen`=1, `sram_wen`=1, `sram_addr` and `sram_d` hold their previous values.
- Simultaneous push and pop: both happen. Occupancy is unchanged, including when the FIFO is full.
- Empty FIFO with `wr_ready`=1: no write strobe.

## Timing
- Reset values: `sram_cen`=1, `sram_wen`=1, `sram_addr`=0, `sram_d`=0, `busy`=0, `done`=0, `overflow`=0, `order_err`=0. State IDLE, FIFO empty.
- Latency with an empty FIFO and `wr_ready` held at 1:
  - `mpl_valid` in cycle t → push at the end of t.
  - Pop at the end of t+1.
  - Write strobe visible in cycle t+2.
- Throughput: one write per cycle while `wr_ready`=1.
- `done`: if the 4th write strobe is visible in cycle w, then `done`=1 in cycle w+1 and `busy`=0 from w+1.
- `busy` rises the cycle after `start`.
- Reset asserted mid-tile: all outputs take their reset values immediately (asynchronous). A write strobe in flight is deasserted, not completed.

## Test plan
- Nominal tile:
  - Stimulus: start with base_addr=4, relu_en=0; pushes at onij 0,1,2,3, spaced 4 cycles apart; `wr_ready`=1.
  - Required: writes to addresses 4,5,6,7, each 2 cycles after its push, with data bit-exact; `done` one cycle after the last write; `overflow`=0, `order_err`=0.
- ReLU:
  - Stimulus: relu_en=1; lane0=16'h8001, lane1=16'h7FFF, lane2=16'h0000, lane3=16'hFFFF.
  - Required: written lanes are 0, 7FFF, 0, 0.
- Backpressure:
  - Stimulus: `wr_ready`=0; 4 back-to-back pushes (depth=4); then `wr_ready`=1.
  - Required: no strobe while `wr_ready`=0; then 4 consecutive writes in onij order; `done`=1; `overflow`=0.
- Overflow:
  - Stimulus: depth=2 build, `wr_ready`=0, 3 pushes.
  - Required: `overflow`=1 after the 3rd push; push count 2; state remains RUN.
- Order error and wrap:
  - Stimulus: base_addr=15; pushes with onij 0,2,1,3.
  - Required: `order_err`=1; writes to addresses 15,1,0,2.
- Restart and reset:
  - Stimulus: `start` after 2 writes.
  - Required: counters cleared; 4 new writes are needed before `done`.
  - Stimulus: `reset` pulse mid-strobe.
  - Required: `sram_cen`/`sram_wen`=1 within the same cycle; all flags 0.

Source files
------------

// File: rtl/mpl_wb_collector.sv
// mpl_wb_collector: queues pooled max-pool words, applies optional ReLU and
// writes them to the output SRAM at base_addr + pooled index, pulsing done
// once all four pooled positions of a tile have been written.
module mpl_wb_collector #(
   parameter int psum_bw = 16,
   parameter int col     = 8,
   parameter int depth   = 4,
   parameter int addr_bw = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [addr_bw-1:0]       base_addr,
   input  logic                     relu_en,
   input  logic                     mpl_valid,
   input  logic [1:0]               mpl_onij,
   input  logic [psum_bw*col-1:0]   mpl_out,
   input  logic                     wr_ready,
   output logic                     sram_cen,
   output logic                     sram_wen,
   output logic [addr_bw-1:0]       sram_addr,
   output logic [psum_bw*col-1:0]   sram_d,
   output logic                     busy,
   output logic                     done,
   output logic                     overflow,
   output logic                     order_err
);

   localparam int pw = $clog2(depth);
   localparam int dw = psum_bw * col;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t               state, state_nxt;

   logic [1:0]           mem_onij [depth];
   logic [dw-1:0]        mem_data [depth];
   logic [pw-1:0]        head, tail;
   logic [pw:0]          count;
   logic [2:0]           push_cnt, wr_cnt;
   logic [1:0]           exp_idx;
   logic [addr_bw-1:0]   base_q;
   logic                 relu_q;
   logic                 active, full, empty, push, pop, drop;

   // Zero every signed lane whose sign bit is set when ReLU is enabled.
   function automatic logic [dw-1:0] apply_relu(input logic [dw-1:0] d, input logic en);
      logic [dw-1:0] r;
      r = d;
      if (en) begin
         for (int unsigned i = 0; i < col; i++) begin
            if (d[i*psum_bw + psum_bw - 1]) r[i*psum_bw +: psum_bw] = '0;
         end
      end
      return r;
   endfunction

   assign active = (state == RUN) || (state == FLUSH);
   assign full   = (count == (pw+1)'(depth));
   assign empty  = (count == '0);
   assign busy   = active;
   assign done   = (state == DONE);

   // Push/pop qualification; start suppresses both so the restart sees a clean FIFO.
   always_comb begin
      pop  = 1'b0;
      push = 1'b0;
      drop = 1'b0;
      if (!start) begin
         pop  = active && !empty && wr_ready;
         push = (state == RUN) && mpl_valid && (!full || pop);
         drop = (state == RUN) && mpl_valid && full && !pop;
      end
   end

   // Next-state decode: tile ends after four accepted pushes and four writes.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = IDLE;
         RUN:     if (push && (push_cnt == 3'd3)) state_nxt = FLUSH;
         FLUSH:   if (empty && (wr_cnt == 3'd4)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (start) state_nxt = RUN;
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // FIFO storage; contents need no reset since occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_onij[tail] <= mpl_onij;
         mem_data[tail] <= mpl_out;
      end
   end

   // FIFO pointers, tile counters, sampled tile config and sticky flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         push_cnt  <= '0;
         wr_cnt    <= '0;
         exp_idx   <= '0;
         base_q    <= '0;
         relu_q    <= 1'b0;
         overflow  <= 1'b0;
         order_err <= 1'b0;
      end else if (start) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         push_cnt  <= '0;
         wr_cnt    <= '0;
         exp_idx   <= '0;
         base_q    <= base_addr;
         relu_q    <= relu_en;
         overflow  <= 1'b0;
         order_err <= 1'b0;
      end else begin
         if (push) begin
            tail     <= tail + 1'b1;
            push_cnt <= push_cnt + 3'd1;
            exp_idx  <= exp_idx + 2'd1;
            if (mpl_onij != exp_idx) order_err <= 1'b1;
         end
         if (pop) begin
            head   <= head + 1'b1;
            wr_cnt <= wr_cnt + 3'd1;
         end
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
         if (drop) overflow <= 1'b1;
      end
   end

   // Registered SRAM write port; address and data hold when no write is issued.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sram_cen  <= 1'b1;
         sram_wen  <= 1'b1;
         sram_addr <= '0;
         sram_d    <= '0;
      end else if (pop) begin
         sram_cen  <= 1'b0;
         sram_wen  <= 1'b0;
         sram_addr <= base_q + addr_bw'(mem_onij[head]);
         sram_d    <= apply_relu(mem_data[head], relu_q);
      end else begin
         sram_cen  <= 1'b1;
         sram_wen  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mpl_wb_collector.sv
// Scoreboard bench for mpl_wb_collector: stimulus pushes expected SRAM writes,
// a negedge monitor pops and compares them and tracks the done pulse.
module tb_mpl_wb_collector;

   localparam int PB  = 16;
   localparam int COL = 8;
   localparam int DW  = PB * COL;
   localparam int AB  = 4;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           start = 1'b0;
   logic [AB-1:0]  base_addr = '0;
   logic           relu_en = 1'b0;
   logic           mpl_valid = 1'b0;
   logic [1:0]     mpl_onij = '0;
   logic [DW-1:0]  mpl_out = '0;
   logic           wr_ready = 1'b0;

   logic           cen, wen, busy, done, ovf, oerr;
   logic [AB-1:0]  addr;
   logic [DW-1:0]  d;
   logic           cen2, wen2, busy2, done2, ovf2, oerr2;
   logic [AB-1:0]  addr2;
   logic [DW-1:0]  d2;

   mpl_wb_collector #(.psum_bw(PB), .col(COL), .depth(4), .addr_bw(AB)) u_dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .relu_en(relu_en),
      .mpl_valid(mpl_valid), .mpl_onij(mpl_onij), .mpl_out(mpl_out), .wr_ready(wr_ready),
      .sram_cen(cen), .sram_wen(wen), .sram_addr(addr), .sram_d(d),
      .busy(busy), .done(done), .overflow(ovf), .order_err(oerr));

   mpl_wb_collector #(.psum_bw(PB), .col(COL), .depth(2), .addr_bw(AB)) u_dut2 (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .relu_en(relu_en),
      .mpl_valid(mpl_valid), .mpl_onij(mpl_onij), .mpl_out(mpl_out), .wr_ready(wr_ready),
      .sram_cen(cen2), .sram_wen(wen2), .sram_addr(addr2), .sram_d(d2),
      .busy(busy2), .done(done2), .overflow(ovf2), .order_err(oerr2));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      logic [AB-1:0] addr;
      logic [DW-1:0] data;
      int            exp_cyc;
   } wr_t;
   wr_t sb[$];

   // reference model state for the current tile
   int  m_base;
   bit  m_relu;
   int  m_idx;
   bit  m_oerr;
   bit  rnd_rdy = 1'b0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] ref_relu(input logic [DW-1:0] w, input bit en);
      logic [DW-1:0] r;
      logic signed [PB-1:0] v;
      r = w;
      for (int i = 0; i < COL; i++) begin
         v = w[i*PB +: PB];
         if (en && v < 0) r[i*PB +: PB] = '0;
      end
      return r;
   endfunction

   function automatic logic [DW-1:0] rnd_word();
      logic [DW-1:0] w;
      for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   // monitor: compares every write strobe and the done pulse timing
   bit mon_exp_done = 1'b0;
   int mon_cnt = 0;
   bit prev_wr = 1'b0;
   always @(negedge clk) begin
      wr_t e;
      if (reset) begin
         mon_cnt = 0;
         mon_exp_done = 1'b0;
      end else begin
         check("done", done, mon_exp_done);
         if (mon_exp_done) check("busy_after_done", busy, 0);
         mon_exp_done = 1'b0;
         if (!cen) begin
            check("wen", wen, 0);
            check("strobe_needs_ready", prev_wr, 1);
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write actual addr=%0d required no write", addr);
            end else begin
               e = sb.pop_front();
               check("addr", addr, e.addr);
               check("data", d, e.data);
               if (e.exp_cyc >= 0) check("write_cycle", cyc, e.exp_cyc);
            end
            mon_cnt++;
            if (mon_cnt == 4) begin
               mon_exp_done = 1'b1;
               mon_cnt = 0;
            end
         end
         if (start) begin
            mon_cnt = 0;
            mon_exp_done = 1'b0;
         end
      end
      prev_wr = wr_ready;
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_rdy) wr_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic do_start(input int base, input bit relu);
      start = 1'b1;
      base_addr = AB'(base);
      relu_en = relu;
      m_base = base;
      m_relu = relu;
      m_idx = 0;
      m_oerr = 1'b0;
      tick();
      start = 1'b0;
      check("busy_after_start", busy, 1);
   endtask

   task automatic push(input int o, input logic [DW-1:0] w, input bit lat);
      wr_t e;
      mpl_valid = 1'b1;
      mpl_onij = 2'(o);
      mpl_out = w;
      if (o != m_idx) m_oerr = 1'b1;
      m_idx++;
      e.addr = AB'((m_base + o) % 16);
      e.data = ref_relu(w, m_relu);
      e.exp_cyc = lat ? cyc + 2 : -1;
      sb.push_back(e);
      tick();
      mpl_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      for (n = 0; n < 80; n++) begin
         if (done) break;
         tick();
      end
      if (n == 80) begin
         checks++;
         errors++;
         $display("FAIL %s_done_timeout actual=no done required=done", name);
      end
      check({name, "_sb_empty"}, DW'(sb.size()), 0);
      check({name, "_order_err"}, oerr, m_oerr);
      check({name, "_overflow"}, ovf, 0);
      tick();
   endtask

   initial begin
      int n;
      logic [DW-1:0] w;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cen", cen, 1);
      check("rst_wen", wen, 1);
      check("rst_addr", addr, 0);
      check("rst_d", d, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ovf", ovf, 0);
      check("rst_oerr", oerr, 0);
      reset = 1'b0;
      tick();

      // nominal tile, pushes 4 cycles apart, latency checked
      wr_ready = 1'b1;
      do_start(4, 0);
      for (int o = 0; o < 4; o++) begin
         push(o, rnd_word(), 1);
         if (o < 3) repeat (3) tick();
      end
      wait_done("nominal");

      // ReLU with fixed lane patterns in the first word
      do_start(3, 1);
      w = rnd_word();
      w[15:0] = 16'h8001;
      w[31:16] = 16'h7FFF;
      w[47:32] = 16'h0000;
      w[63:48] = 16'hFFFF;
      push(0, w, 1);
      for (int o = 1; o < 4; o++) push(o, rnd_word(), 1);
      wait_done("relu");

      // backpressure: fill while blocked, then four consecutive writes
      wr_ready = 1'b0;
      do_start(8, 0);
      for (int o = 0; o < 4; o++) push(o, rnd_word(), 0);
      repeat (3) tick();
      for (int i = 0; i < 4; i++) sb[i].exp_cyc = cyc + 1 + i;
      wr_ready = 1'b1;
      wait_done("backpressure");

      // overflow on the depth-2 instance
      wr_ready = 1'b0;
      do_start(0, 0);
      for (int o = 0; o < 3; o++) push(o, rnd_word(), 0);
      check("ovf2_set", ovf2, 1);
      check("busy2_run", busy2, 1);
      check("ovf1_clear", ovf, 0);
      wr_ready = 1'b1;
      n = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (!cen2) n++;
      end
      check("ovf2_writes", n, 2);
      check("ovf2_no_done", busy2, 1);
      push(3, rnd_word(), 0);
      wait_done("overflow");

      // order error with address wrap
      do_start(15, 0);
      push(0, rnd_word(), 1);
      tick();
      push(2, rnd_word(), 1);
      tick();
      push(1, rnd_word(), 1);
      tick();
      push(3, rnd_word(), 1);
      check("order_err_set", oerr, 1);
      wait_done("order");

      // restart after two writes
      do_start(2, 0);
      push(0, rnd_word(), 1);
      push(1, rnd_word(), 1);
      repeat (4) tick();
      check("restart_sb_empty", DW'(sb.size()), 0);
      do_start(6, 1);
      for (int o = 0; o < 4; o++) push(o, rnd_word(), 1);
      wait_done("restart");

      // random tiles with random wr_ready
      for (int t = 0; t < 4; t++) begin
         rnd_rdy = 1'b1;
         do_start($urandom_range(0, 15), 1'($urandom_range(0, 1)));
         for (int o = 0; o < 4; o++) begin
            push(($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : o, rnd_word(), 0);
            repeat ($urandom_range(0, 2)) tick();
         end
         wait_done("random");
         rnd_rdy = 1'b0;
         wr_ready = 1'b1;
      end

      // reset pulse while a write strobe is visible
      do_start(5, 0);
      push(1, rnd_word(), 0);
      tick();
      check("strobe_before_reset", cen, 0);
      check("oerr_before_reset", oerr, 1);
      #2;
      reset = 1'b1;
      #1;
      check("async_cen", cen, 1);
      check("async_wen", wen, 1);
      check("async_addr", addr, 0);
      check("async_d", d, 0);
      check("async_busy", busy, 0);
      check("async_done", done, 0);
      check("async_oerr", oerr, 0);
      check("async_ovf", ovf, 0);
      check("async_cen2", cen2, 1);
      check("async_busy2", busy2, 0);
      check("async_ovf2", ovf2, 0);
      sb.delete();
      tick();
      reset = 1'b0;
      tick();
      check("idle_after_reset", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
